// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between mux_scan_ctrl, its requester and the muxN it drives.
// Handshake: start is taken on the first rising edge where ready=1; done pulses for one cycle when the scan ends.
interface mux_scan_ctrl_if #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) ();
  logic             start;
  logic [N-1:0]     word_in;
  logic             ready;
  logic [N-1:0]     x_out;
  logic [SEL_W-1:0] sel;
  logic             y_in;
  logic [N-1:0]     word_out;
  logic             done;
  logic             match;

  modport master (
    output start, word_in, y_in,
    input  ready, x_out, sel, word_out, done, match
  );

  modport slave (
    input  start, word_in, y_in,
    output ready, x_out, sel, word_out, done, match
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Drives a latched word into muxN, steps its select through 0..N-1 holding each for DIV clocks,
// and rebuilds the word from the mux output so the path can be checked end to end.
module mux_scan_ctrl #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N),
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_scan_ctrl_if.slave     bus,
  output logic [1:0]         dbg_state_o
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     x_q, x_d;
  logic [N-1:0]     word_q, word_d;
  logic             match_q, match_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      x_q     <= '0;
      word_q  <= '0;
      match_q <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      word_q  <= word_d;
      match_q <= match_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    word_d  = word_q;
    match_d = match_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.word_in;
          sel_d   = '0;
          div_d   = '0;
          word_d  = '0;
          match_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (div_q == DIV_W'(DIV - 1)) begin
          // The mux has had DIV clocks to settle on this select value.
          word_d[sel_q] = bus.y_in;
          div_d         = '0;
          if (sel_q == SEL_W'(N - 1)) begin
            match_d = (word_d == x_q);
            state_d = DONE;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.x_out    = x_q;
  assign bus.sel      = sel_q;
  assign bus.word_out = word_q;
  assign bus.match    = match_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: vector table of scans through a modelled muxN with bit forcing,
// plus hand-written sequences for ignored start, mid-scan reset, back-to-back and DIV=1.
module tb_mux_scan_ctrl;

  localparam int N   = 8;
  localparam int SW  = 3;
  localparam int DIV = 4;
  localparam int SCAN_LEN = N * DIV;

  logic clk;
  logic reset;
  logic [1:0] dbg0, dbg1;

  mux_scan_ctrl_if #(.N(N), .SEL_W(SW)) bus ();
  mux_scan_ctrl_if #(.N(N), .SEL_W(SW)) bus1 ();

  mux_scan_ctrl #(.N(N), .SEL_W(SW), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state_o(dbg0)
  );
  mux_scan_ctrl #(.N(N), .SEL_W(SW), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state_o(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // muxN model with an optional stuck bit on one select value
  logic      force_en;
  int        force_sel;
  logic      force_val;
  assign bus.y_in  = (force_en && (int'(bus.sel) == force_sel)) ? force_val : bus.x_out[bus.sel];
  assign bus1.y_in = bus1.x_out[bus1.sel];

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboards: pop expected {word_out, match} whenever done is seen
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result", {bus.word_out, bus.match}, e);
      end
    end
    if (!reset && bus1.done) begin
      if (exp1_q.size() == 0) check("unexpected_done_div1", 1, 0);
      else begin
        logic [8:0] e;
        e = exp1_q.pop_front();
        check("result_div1", {bus1.word_out, bus1.match}, e);
      end
    end
  end

  typedef struct {
    logic [7:0] word;
    int         force_sel;
    logic       force_val;
    logic [7:0] exp_word;
    logic       exp_match;
    int         poke_sel;
    logic [7:0] poke_word;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [SW+1:0] exp_timing(input int t, input int div);
    logic [SW-1:0] s;
    if (t < N * div)       s = SW'(t / div);
    else if (t == N * div) s = SW'(N - 1);
    else                   s = '0;
    return {s, 1'(t == N * div), 1'(t == N * div + 1)};
  endfunction

  // driver: one scan, checking sel/done/ready every cycle from the accept edge (t=0)
  task automatic run_vec(input vec_t v);
    force_en  = (v.force_sel >= 0);
    force_sel = v.force_sel;
    force_val = v.force_val;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.word_in = v.word;
    exp_q.push_back({v.exp_word, v.exp_match});
    @(posedge clk);
    for (int t = 0; t <= SCAN_LEN + 1; t++) begin
      @(negedge clk);
      check("timing", {bus.sel, bus.done, bus.ready}, exp_timing(t, DIV));
      if (v.poke_sel >= 0 && t == v.poke_sel * DIV) begin
        bus.start   = 1'b1;
        bus.word_in = v.poke_word;
      end else begin
        bus.start   = 1'b0;
        bus.word_in = 8'($urandom_range(0, 255));
      end
    end
    check("x_out_hold", bus.x_out, v.word);
    force_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'b10101100, -1, 1'b0, 8'b10101100, 1'b1, -1, 8'h00};
    vecs[1] = '{8'b10101100,  2, 1'b0, 8'b10101000, 1'b0, -1, 8'h00};
    vecs[2] = '{8'hF0,       -1, 1'b0, 8'hF0,       1'b1,  3, 8'h0F};
    vecs[3] = '{8'h00,       -1, 1'b0, 8'h00,       1'b1, -1, 8'h00};
    vecs[4] = '{8'hFF,        7, 1'b0, 8'h7F,       1'b0, -1, 8'h00};
    vecs[5] = '{8'h00,        4, 1'b1, 8'h10,       1'b0, -1, 8'h00};
    vecs[6] = '{8'h96,        0, 1'b0, 8'h96,       1'b1,  6, 8'h69};

    force_en     = 1'b0;
    force_sel    = -1;
    force_val    = 1'b0;
    bus.start    = 1'b0;
    bus.word_in  = '0;
    bus1.start   = 1'b0;
    bus1.word_in = '0;
    reset        = 1'b1;

    @(negedge clk);
    check("reset_outputs", {bus.ready, bus.sel, bus.x_out, bus.word_out, bus.done, bus.match},
          {1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0});
    check("reset_state", dbg0, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset part-way through a scan, during sel=5
    @(negedge clk);
    bus.start   = 1'b1;
    bus.word_in = 8'hA5;
    exp_q.push_back({8'hA5, 1'b1});
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    check("pre_reset_sel", bus.sel, 3'd5);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_outputs", {bus.ready, bus.sel, bus.x_out, bus.word_out, bus.done, bus.match},
          {1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    begin
      int pulses = 0;
      for (int t = 0; t < SCAN_LEN + 4; t++) begin
        @(negedge clk);
        if (bus.done) pulses++;
      end
      check("no_done_after_reset", pulses, 0);
      check("idle_after_reset", bus.ready, 1'b1);
    end
    run_vec('{8'h5A, -1, 1'b0, 8'h5A, 1'b1, -1, 8'h00});

    // start held high: accepts at 0, P, 2P where P = scan + done + one idle cycle
    begin
      int p;
      p = SCAN_LEN + 2;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.word_in = 8'h3C;
      repeat (3) exp_q.push_back({8'h3C, 1'b1});
      @(posedge clk);
      for (int t = 0; t < 3 * p; t++) begin
        @(negedge clk);
        check("b2b_done_ready", {bus.done, bus.ready},
              {1'((t % p) == SCAN_LEN), 1'((t % p) == SCAN_LEN + 1)});
        if (t >= 2 * p) bus.start = 1'b0;
      end
      check("b2b_drained", exp_q.size(), 0);
    end

    // DIV=1 instance: select moves every clock
    @(negedge clk);
    bus1.start   = 1'b1;
    bus1.word_in = 8'h81;
    exp1_q.push_back({8'h81, 1'b1});
    @(posedge clk);
    for (int t = 0; t <= N + 1; t++) begin
      @(negedge clk);
      bus1.start   = 1'b0;
      bus1.word_in = 8'($urandom_range(0, 255));
      check("div1_timing", {bus1.sel, bus1.done, bus1.ready}, exp_timing(t, 1));
    end
    check("div1_x_out", bus1.x_out, 8'h81);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("queue1_empty", exp1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
